csr_access_sequencer: RTL and testbench

Pipeline-side initiator for the CSR register file's read/write interface. It accepts one Zicsr instruction at a time from the execute stage: CSRRW, CSRRS, CSRRC and their immediate forms. For each instruction it runs a sequenced read-modify-write against the CSR block, applying privilege and read-only checks before any write. It then returns the old CSR value, or an illegal-instruction flag, to writeback over a valid/ready handshake.

---
 rtl/csr_access_sequencer.sv | 128 ++++++++++++
 tb/tb_csr_access_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_sequencer.sv
// Zicsr read-modify-write sequencer between the execute stage and the CSR register file.
// Each instruction is read, checked for privilege and read-only violations, optionally written, then answered.
module csr_access_sequencer #(
  parameter int C_XLEN = 32
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              clk_en_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_op_i,
  input  logic [11:0]       req_addr_i,
  input  logic [4:0]        req_rs1_i,
  input  logic [C_XLEN-1:0] req_rs1_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [C_XLEN-1:0] rsp_data_o,
  output logic              rsp_illegal_o,
  output logic              csr_access_o,
  output logic [11:0]       csr_addr_o,
  output logic [C_XLEN-1:0] csr_data_o,
  input  logic [C_XLEN-1:0] csr_data_i,
  input  logic              csr_illegal_i,
  input  logic [1:0]        hpl_i,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t              state;
  logic [1:0]          op_q;
  logic                write_req_q;
  logic [C_XLEN-1:0]   operand_q;
  logic [C_XLEN-1:0]   old_q;

  logic [C_XLEN-1:0]   operand_d;
  logic                write_req_d;
  logic                illegal_d;
  logic [C_XLEN-1:0]   new_value;

  // Handshakes: a transfer happens on an enabled rising edge where valid and ready are both high;
  // the request side is ready only in IDLE, and the response is held stable while valid until taken.
  assign req_ready_o = (state == ST_IDLE);
  assign dbg_state_o = state;

  always_comb begin
    operand_d   = req_op_i[2] ? {{(C_XLEN-5){1'b0}}, req_rs1_i} : req_rs1_data_i;
    write_req_d = !(req_op_i[1] && (req_rs1_i == 5'd0));
  end

  // csr_addr_o carries the latched address, so it doubles as the address under check.
  always_comb begin
    illegal_d = csr_illegal_i
              | (csr_addr_o[9:8] > hpl_i)
              | (op_q == 2'b00)
              | (write_req_q & (csr_addr_o[11:10] == 2'b11));
  end

  always_comb begin
    new_value = operand_q;
    case (op_q)
      2'b10:   new_value = csr_data_i | operand_q;
      2'b11:   new_value = csr_data_i & ~operand_q;
      default: new_value = operand_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state         <= ST_IDLE;
      op_q          <= 2'b00;
      write_req_q   <= 1'b0;
      operand_q     <= '0;
      old_q         <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_data_o    <= '0;
      rsp_illegal_o <= 1'b0;
      csr_access_o  <= 1'b0;
      csr_addr_o    <= '0;
      csr_data_o    <= '0;
    end else if (clk_en_i) begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            op_q        <= req_op_i[1:0];
            write_req_q <= write_req_d;
            operand_q   <= operand_d;
            csr_addr_o  <= req_addr_i;
            state       <= ST_READ;
          end
        end
        ST_READ: begin
          old_q         <= csr_data_i;
          rsp_illegal_o <= illegal_d;
          if (write_req_q && !illegal_d) begin
            csr_access_o <= 1'b1;
            csr_data_o   <= new_value;
            state        <= ST_WRITE;
          end else begin
            // Illegal instructions never expose the CSR contents.
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= illegal_d ? '0 : csr_data_i;
            state       <= ST_RESP;
          end
        end
        ST_WRITE: begin
          csr_access_o <= 1'b0;
          rsp_valid_o  <= 1'b1;
          rsp_data_o   <= old_q;
          state        <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Directed and randomized bench for csr_access_sequencer against a behavioural CSR/Zicsr model.
module tb_csr_access_sequencer;
  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            resetb_i;
  logic            clk_en_i;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [2:0]      req_op_i;
  logic [11:0]     req_addr_i;
  logic [4:0]      req_rs1_i;
  logic [XLEN-1:0] req_rs1_data_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [XLEN-1:0] rsp_data_o;
  logic            rsp_illegal_o;
  logic            csr_access_o;
  logic [11:0]     csr_addr_o;
  logic [XLEN-1:0] csr_data_o;
  logic [XLEN-1:0] csr_data_i;
  logic            csr_illegal_i;
  logic [1:0]      hpl_i;
  logic [1:0]      dbg_state_o;

  // clock / reset
  always #5 clk_i = ~clk_i;

  csr_access_sequencer #(.C_XLEN(XLEN)) dut (
    .clk_i(clk_i), .resetb_i(resetb_i), .clk_en_i(clk_en_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_addr_i(req_addr_i), .req_rs1_i(req_rs1_i), .req_rs1_data_i(req_rs1_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_illegal_o(rsp_illegal_o), .csr_access_o(csr_access_o), .csr_addr_o(csr_addr_o),
    .csr_data_o(csr_data_o), .csr_data_i(csr_data_i), .csr_illegal_i(csr_illegal_i),
    .hpl_i(hpl_i), .dbg_state_o(dbg_state_o)
  );

  // behavioural CSR file: contents and unimplemented map
  logic [XLEN-1:0] csr_mem [0:4095];
  logic            unimpl  [0:4095];
  assign csr_data_i    = csr_mem[csr_addr_o];
  assign csr_illegal_i = unimpl[csr_addr_o];

  // write monitor: one count per enabled edge with the strobe high
  int          wr_cnt = 0;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  always @(posedge clk_i) begin
    if (resetb_i && clk_en_i && csr_access_o) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = csr_addr_o;
      wr_data = csr_data_o;
    end
  end

  // scoreboard
  logic [XLEN-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_instr(input logic [2:0] op, input logic [11:0] addr, input logic [4:0] rs1,
                          input logic [31:0] rs1_data, input logic [1:0] hpl, input int delay,
                          input bit toggle_en);
    logic [31:0] operand, old_val, new_val, exp_rd;
    logic        writes, ill, exp_write;
    int          lat, base;
    operand = op[2] ? {27'd0, rs1} : rs1_data;
    old_val = csr_mem[addr];
    writes  = !((op == 3'b010 || op == 3'b011 || op == 3'b110 || op == 3'b111) && rs1 == 0);
    ill     = unimpl[addr] || (addr[9:8] > hpl) || (op == 3'b000 || op == 3'b100)
              || (writes && addr[11:10] == 2'b11);
    case (op)
      3'b010, 3'b110: new_val = old_val | operand;
      3'b011, 3'b111: new_val = old_val & ~operand;
      default:        new_val = operand;
    endcase
    exp_write = writes && !ill;
    exp_q.push_back(ill ? 32'd0 : old_val);
    base  = wr_cnt;
    hpl_i = hpl;
    chk("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_op_i = op; req_addr_i = addr;
    req_rs1_i = rs1; req_rs1_data_i = rs1_data;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_rs1_data_i = $urandom;
    chk("req_ready_busy", {31'd0, req_ready_o}, 32'd0);
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!rsp_valid_o && lat < 20);
    if (!rsp_valid_o) begin
      chk("rsp_timeout", {31'd0, rsp_valid_o}, 32'd1);
      return;
    end
    exp_rd = exp_q.pop_front();
    chk("latency", lat, exp_write ? 32'd2 : 32'd1);
    chk("rsp_data", rsp_data_o, exp_rd);
    chk("rsp_illegal", {31'd0, rsp_illegal_o}, {31'd0, ill});
    chk("csr_addr_hold", {20'd0, csr_addr_o}, {20'd0, addr});
    chk("write_count", wr_cnt - base, exp_write ? 32'd1 : 32'd0);
    if (exp_write) begin
      chk("write_addr", {20'd0, wr_addr}, {20'd0, addr});
      chk("write_data", wr_data, new_val);
      csr_mem[addr] = new_val;
    end
    rsp_ready_i = 1'b0;
    for (int i = 0; i < delay; i++) begin
      if (toggle_en) clk_en_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      chk("hold_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("hold_data", rsp_data_o, exp_rd);
      chk("hold_illegal", {31'd0, rsp_illegal_o}, {31'd0, ill});
      chk("hold_ready_low", {31'd0, req_ready_o}, 32'd0);
    end
    clk_en_i = 1'b1;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk("post_hs_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("post_hs_ready", {31'd0, req_ready_o}, 32'd1);
    chk("post_hs_write_count", wr_cnt - base, exp_write ? 32'd1 : 32'd0);
  endtask

  logic [11:0] addr_pool [0:9];
  logic [2:0]  op_pool   [0:7];

  initial begin
    int base;
    logic [31:0] old_val;
    for (int i = 0; i < 4096; i++) begin
      csr_mem[i] = $urandom;
      unimpl[i]  = 1'b0;
    end
    unimpl[12'h7C0] = 1'b1;
    unimpl[12'h3FF] = 1'b1;
    addr_pool[0] = 12'h340; addr_pool[1] = 12'h341; addr_pool[2] = 12'h305; addr_pool[3] = 12'hC00;
    addr_pool[4] = 12'hC01; addr_pool[5] = 12'h100; addr_pool[6] = 12'h140; addr_pool[7] = 12'h7C0;
    addr_pool[8] = 12'h3FF; addr_pool[9] = 12'h001;
    op_pool[0] = 3'b001; op_pool[1] = 3'b010; op_pool[2] = 3'b011; op_pool[3] = 3'b101;
    op_pool[4] = 3'b110; op_pool[5] = 3'b111; op_pool[6] = 3'b000; op_pool[7] = 3'b100;

    resetb_i = 1'b0; clk_en_i = 1'b1; req_valid_i = 1'b0; req_op_i = '0; req_addr_i = '0;
    req_rs1_i = '0; req_rs1_data_i = '0; rsp_ready_i = 1'b0; hpl_i = 2'b11;
    repeat (2) @(negedge clk_i);
    chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_rsp_data", rsp_data_o, 32'd0);
    chk("rst_csr_access", {31'd0, csr_access_o}, 32'd0);
    chk("rst_csr_addr", {20'd0, csr_addr_o}, 32'd0);
    chk("rst_csr_data", csr_data_o, 32'd0);
    resetb_i = 1'b1;
    @(negedge clk_i);
    chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_state", {30'd0, dbg_state_o}, 32'd0);

    // directed cases
    csr_mem[12'h340] = 32'h12345678;
    do_instr(3'b001, 12'h340, 5'd7, 32'hDEADBEEF, 2'b11, 0, 1'b0);
    chk("mscratch_written", csr_mem[12'h340], 32'hDEADBEEF);
    csr_mem[12'hC00] = 32'h0000_0055;
    do_instr(3'b010, 12'hC00, 5'd0, 32'hFFFF_FFFF, 2'b11, 1, 1'b0);
    do_instr(3'b111, 12'hC00, 5'd5, 32'h0, 2'b11, 0, 1'b0);
    do_instr(3'b101, 12'h300, 5'd3, 32'h0, 2'b00, 0, 1'b0);
    csr_mem[12'h305] = 32'h0000_0001;
    do_instr(3'b110, 12'h305, 5'h0A, 32'h0, 2'b11, 0, 1'b0);
    chk("csrrsi_value", csr_mem[12'h305], 32'h0000_000B);
    do_instr(3'b000, 12'h340, 5'd1, 32'h1, 2'b11, 0, 1'b0);
    do_instr(3'b001, 12'h7C0, 5'd1, 32'h1, 2'b11, 0, 1'b0);
    do_instr(3'b011, 12'h341, 5'd9, 32'h0F0F_0F0F, 2'b11, 5, 1'b1);

    // clock-enable freeze while the write strobe is pending
    old_val = csr_mem[12'h341];
    base = wr_cnt;
    req_valid_i = 1'b1; req_op_i = 3'b001; req_addr_i = 12'h341; req_rs1_i = 5'd3;
    req_rs1_data_i = 32'hCAFE_F00D; hpl_i = 2'b11;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("frz_access_on", {31'd0, csr_access_o}, 32'd1);
    chk("frz_access_data", csr_data_o, 32'hCAFE_F00D);
    clk_en_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      chk("frz_access_held", {31'd0, csr_access_o}, 32'd1);
      chk("frz_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
      chk("frz_no_write", wr_cnt - base, 32'd0);
    end
    clk_en_i = 1'b1;
    @(negedge clk_i);
    chk("frz_access_off", {31'd0, csr_access_o}, 32'd0);
    chk("frz_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    chk("frz_rsp_data", rsp_data_o, old_val);
    chk("frz_write_once", wr_cnt - base, 32'd1);
    csr_mem[12'h341] = 32'hCAFE_F00D;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk("frz_idle", {31'd0, req_ready_o}, 32'd1);

    // asynchronous reset in the middle of WRITE
    old_val = csr_mem[12'h140];
    base = wr_cnt;
    req_valid_i = 1'b1; req_op_i = 3'b001; req_addr_i = 12'h140; req_rs1_i = 5'd4;
    req_rs1_data_i = 32'h1234_ABCD; hpl_i = 2'b11;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("rstw_access_on", {31'd0, csr_access_o}, 32'd1);
    #1 resetb_i = 1'b0;
    #1;
    chk("rstw_access_drop", {31'd0, csr_access_o}, 32'd0);
    chk("rstw_csr_addr", {20'd0, csr_addr_o}, 32'd0);
    chk("rstw_csr_data", csr_data_o, 32'd0);
    chk("rstw_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rstw_state", {30'd0, dbg_state_o}, 32'd0);
    @(negedge clk_i);
    resetb_i = 1'b1;
    @(negedge clk_i);
    chk("rstw_no_write", wr_cnt - base, 32'd0);
    chk("rstw_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rstw_mem_kept", csr_mem[12'h140], old_val);

    // randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      logic [4:0] rs1;
      logic [1:0] hpl;
      rs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      case ($urandom_range(0, 2))
        0: hpl = 2'b00;
        1: hpl = 2'b01;
        default: hpl = 2'b11;
      endcase
      do_instr(op_pool[$urandom_range(0, 7)], addr_pool[$urandom_range(0, 9)], rs1, $urandom,
               hpl, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
